// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch I, load/store D) arbiter for one unified memory port, with a watchdog.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-first.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,

    output logic              err_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_d_q, owner_d_d;  // 1: transaction belongs to port D
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WdW-1:0]    wdog_q, wdog_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_i_q, last_i_d;  // last grant went to I; reset value makes D win first

    assign grant_d = d_req_i && (!i_req_i || last_i_q);

    always_comb begin
        last_i_d = last_i_q;
        if (state_q == StIdle && (i_req_i || d_req_i)) begin
            last_i_d = !grant_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_i_q <= 1'b1;
        end else begin
            last_i_q <= last_i_d;
        end
    end
`else
    assign grant_d = d_req_i;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wdog_d    = wdog_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (i_req_i || d_req_i) begin
                    owner_d_d = grant_d;
                    we_d      = grant_d ? d_we_i : 1'b0;
                    addr_d    = grant_d ? d_addr_i : i_addr_i;
                    wdata_d   = grant_d ? d_wdata_i : '0;
                    wdog_d    = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                // A late ack on the final watchdog cycle still counts as success.
                if (mem_ack_i) begin
                    err_d   = 1'b0;
                    state_d = StResp;
                    if (owner_d_q) begin
                        d_rdata_d = mem_rdata_i;
                    end else begin
                        i_rdata_d = mem_rdata_i;
                    end
                end else if (wdog_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                    if (owner_d_q) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wdog_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wdog_q    <= wdog_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode registered state only; reset clears them asynchronously.
    assign mem_req_o   = (state_q == StBusy);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;

    assign i_ack_o   = (state_q == StResp) && !owner_d_q;
    assign d_ack_o   = (state_q == StResp) && owner_d_q;
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory model (TIMEOUT=4).
module tb_mem_port_arbiter;

    localparam logic [31:0] Key = 32'hA5A5_5A5A;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic        i_ack_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_ack_o    (i_ack_o),
        .i_rdata_o  (i_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ack_o    (d_ack_o),
        .d_rdata_o  (d_rdata_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_lat = 0;  // ack on this BUSY cycle index; -1 never acks
    int   mem_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: read data is the address scrambled with Key.
    always @(negedge clk_i) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (rst_i || !mem_req_o) begin
            mem_cnt = 0;
        end else if (mem_cnt == mem_lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_addr_o ^ Key;
            mem_cnt     = 0;
        end else begin
            mem_cnt++;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && (i_ack_o || d_ack_o)) begin
            check("ack_onehot", {63'd0, i_ack_o & d_ack_o}, 64'd0);
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {63'd0, d_ack_o}, {63'd0, mon_e.is_d});
                check("ack_err", {63'd0, err_o}, {63'd0, mon_e.err});
                if (mon_e.chk_rdata) begin
                    check("ack_rdata", {32'd0, mon_e.is_d ? d_rdata_o : i_rdata_o},
                          {32'd0, mon_e.rdata});
                end
            end
        end
    end

    task automatic push(input bit is_d, input logic [31:0] rdata, input bit chk, input bit err);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.chk_rdata = chk; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_mem_req(input string tag);
        int k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!mem_req_o && k < 20);
        check(tag, {63'd0, mem_req_o}, 64'd1);
    endtask

    task automatic wait_ack(input bit is_d, input string tag);
        int k = 0;
        while (!(is_d ? d_ack_o : i_ack_o) && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        check(tag, {63'd0, is_d ? d_ack_o : i_ack_o}, 64'd1);
    endtask

    initial begin
        int n;

        repeat (2) @(negedge clk_i);
        check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_acks", {62'd0, i_ack_o, d_ack_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check("rst_rdata", {i_rdata_o, d_rdata_o}, 64'd0);
        check("rst_mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o[30:0]}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single I read, zero-wait memory
        mem_lat  = 0;
        i_addr_i = 32'hDEADBEEF ^ Key;
        i_req_i  = 1'b1;
        push(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk_i);
        check("t1_mem_req", {63'd0, mem_req_o}, 64'd1);
        check("t1_mem_addr", {32'd0, mem_addr_o}, {32'd0, 32'hDEADBEEF ^ Key});
        check("t1_early_ack", {63'd0, i_ack_o}, 64'd0);
        @(negedge clk_i);
        check("t1_i_ack", {63'd0, i_ack_o}, 64'd1);
        check("t1_no_d_ack", {63'd0, d_ack_o}, 64'd0);
        i_req_i = 1'b0;
        @(negedge clk_i);
        check("t1_pulse", {63'd0, i_ack_o}, 64'd0);

        // D write, memory acks on the second BUSY cycle
        mem_lat   = 1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h40;
        d_wdata_i = 32'h12345678;
        d_req_i   = 1'b1;
        push(1'b1, 32'h0, 1'b0, 1'b0);
        wait_mem_req("t2_mem_req");
        n = 0;
        while (mem_req_o && n < 20) begin
            check("t2_we", {63'd0, mem_we_o}, 64'd1);
            check("t2_addr", {32'd0, mem_addr_o}, 64'h40);
            check("t2_wdata", {32'd0, mem_wdata_o}, 64'h12345678);
            n++;
            @(negedge clk_i);
        end
        check("t2_busy_len", 64'(n), 64'd2);
        d_req_i = 1'b0;
        wait_ack(1'b1, "t2_d_ack");
        d_we_i = 1'b0;
        @(negedge clk_i);

        // D drops its request right after the grant
        mem_lat  = 2;
        d_addr_i = 32'h240;
        d_req_i  = 1'b1;
        push(1'b1, 32'h240 ^ Key, 1'b1, 1'b0);
        @(negedge clk_i);
        d_req_i = 1'b0;
        check("t6_mem_req", {63'd0, mem_req_o}, 64'd1);
        check("t6_mem_addr", {32'd0, mem_addr_o}, 64'h240);
        wait_ack(1'b1, "t6_d_ack");
        @(negedge clk_i);

        // Reset in the middle of a stalled transaction
        mem_lat  = -1;
        i_addr_i = 32'h100;
        i_req_i  = 1'b1;
        wait_mem_req("t5_mem_req");
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("t5_rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("t5_rst_acks", {62'd0, i_ack_o, d_ack_o}, 64'd0);
        i_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        mem_lat = 0;
        i_req_i = 1'b1;
        push(1'b0, 32'h100 ^ Key, 1'b1, 1'b0);
        wait_mem_req("t5_post_mem_req");
        wait_ack(1'b0, "t5_post_i_ack");
        i_req_i = 1'b0;
        @(negedge clk_i);

        // Contention for four transactions
        mem_lat  = 1;
        i_addr_i = 32'h100;
        d_addr_i = 32'h200;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b1, 32'h200 ^ Key, 1'b1, 1'b0);
        push(1'b0, 32'h100 ^ Key, 1'b1, 1'b0);
        push(1'b1, 32'h200 ^ Key, 1'b1, 1'b0);
        push(1'b0, 32'h100 ^ Key, 1'b1, 1'b0);
`else
        repeat (4) push(1'b1, 32'h200 ^ Key, 1'b1, 1'b0);
`endif
        i_req_i = 1'b1;
        d_req_i = 1'b1;
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk_i);
            if (i_ack_o || d_ack_o) n++;
        end
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        check("t3_ack_count", 64'(n), 64'd4);
        repeat (6) @(negedge clk_i);
        check("t3_drained", 64'(sb.size()), 64'd0);

        // Watchdog expiry, then an ack on the last allowed cycle
        mem_lat  = -1;
        d_addr_i = 32'h300;
        d_req_i  = 1'b1;
        push(1'b1, 32'h0, 1'b1, 1'b1);
        wait_mem_req("t4_mem_req");
        n = 0;
        while (mem_req_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check("t4_to_req_len", 64'(n), 64'd4);
        d_req_i = 1'b0;
        wait_ack(1'b1, "t4_to_ack");
        @(negedge clk_i);
        mem_lat  = 3;
        d_addr_i = 32'h304;
        d_req_i  = 1'b1;
        push(1'b1, 32'h304 ^ Key, 1'b1, 1'b0);
        wait_mem_req("t4_late_mem_req");
        n = 0;
        while (mem_req_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check("t4_late_req_len", 64'(n), 64'd4);
        d_req_i = 1'b0;
        wait_ack(1'b1, "t4_late_ack");

        repeat (3) @(negedge clk_i);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single memory port between the instruction-fetch requester (port I) and the load/store requester (port D) of the CPU datapath. It registers one request at a time, drives the memory-side handshake, and returns read data to the winning requester with a one-cycle acknowledge pulse. It sits between the PC/fetch logic and the data-access stage on one side and a single-ported unified memory on the other. A per-transaction watchdog guarantees forward progress if the memory never acknowledges.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in BUSY without mem_ack_i before forced error completion (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- i_req_i  in  1  port I request (read only), level, held until i_ack_o
- i_addr_i  in  ADDR_W  port I address
- i_ack_o  out  1  port I completion pulse, 1 cycle
- i_rdata_o  out  DATA_W  port I read data, valid with i_ack_o
- d_req_i  in  1  port D request, level, held until d_ack_o
- d_we_i  in  1  port D write enable
- d_addr_i  in  ADDR_W  port D address
- d_wdata_i  in  DATA_W  port D write data
- d_ack_o  out  1  port D completion pulse, 1 cycle
- d_rdata_o  out  DATA_W  port D read data, valid with d_ack_o
- err_o  out  1  qualifies the ack pulse of the same cycle: 1 = timed out
- mem_req_o  out  1  memory request, held until mem_ack_i or timeout
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion pulse
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i

## Operation
- FSM: IDLE, BUSY, RESP.
- IDLE: if any req high, pick winner, latch we/addr/wdata (I port: we=0, wdata=0) and owner into registers, clear watchdog, go BUSY. No req: stay.
- Arbitration (default): D beats I when both requesting.
- BUSY: mem_req_o=1 with latched fields. mem_ack_i=1: latch mem_rdata_i, err=0, go RESP. Else watchdog+1; watchdog==TIMEOUT-1 without ack: rdata=0, err=1, go RESP. Ack and timeout same cycle: ack wins, err=0.
- RESP: owner's ack_o=1, its rdata_o=latched data, err_o=latched err; other port ack_o=0; go IDLE.
- Writes also complete through RESP; rdata_o is don't-care for writes.
- Requester inputs are ignored outside IDLE; dropping req mid-transaction does not cancel it; ack is still issued.
- mem_ack_i outside BUSY is ignored.
- rdata_o/err_o hold their last value between acks; consumers qualify with ack.

## Timing
- Reset (async): state IDLE, all outputs 0, watchdog 0, latched data 0, round-robin pointer favours D.
- All outputs registered; no combinational input-to-output path.
- req sampled at edge N → mem_req_o high from N+1.
- mem_ack_i sampled at edge M → ack_o pulse at M+1 → back in IDLE, new request sampled at M+2 → mem_req_o at M+3. Minimum 3 cycles per transaction with zero-wait memory (ack in first BUSY cycle).
- Timeout: mem_req_o high exactly TIMEOUT cycles, then drops; error ack the next cycle.
- Reset asserted mid-BUSY: mem_req_o drops immediately; transaction is lost and no ack is issued.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted last (pointer updated on every grant, including uncontested grants). Not defined: fixed priority, D over I; I can starve under continuous D traffic.

## Test plan
- Single I read, mem ack in first BUSY cycle, mem_rdata_i=32'hDEADBEEF → i_ack_o one cycle with i_rdata_o=32'hDEADBEEF, err_o=0, d_ack_o=0, 3 cycles from req to ack.
- D write addr 32'h40 wdata 32'h12345678 → mem_we_o=1, mem_addr_o=32'h40, mem_wdata_o=32'h12345678 for the whole BUSY, then d_ack_o pulse.
- Both req held for 4 transactions, ack each after 2 cycles → fixed: D,D,D,D; with MEM_ARB_ROUND_ROBIN_EN: D,I,D,I.
- TIMEOUT=4, mem_ack_i never asserted → mem_req_o high exactly 4 cycles, then owner ack with err_o=1, rdata_o=0; ack on 4th cycle instead → err_o=0.
- rst_i asserted mid-BUSY → mem_req_o and all acks 0 immediately; after release, a new I read completes normally.
- Requester drops d_req_i one cycle after the grant → memory transaction still runs; d_ack_o is still issued.
